// File: rtl/kbd_regs_pkg.sv
// Shared register-map constants, response codes and read-FSM state type
// for the keyboard scancode register block.
package kbd_regs_pkg;

   localparam logic [1:0] REG_STATUS  = 2'd0;
   localparam logic [1:0] REG_DATA    = 2'd1;
   localparam logic [1:0] REG_CONTROL = 2'd2;
   localparam logic [1:0] REG_ID      = 2'd3;

   localparam int CTRL_FLUSH   = 0;
   localparam int CTRL_CLR_OVF = 1;
   localparam int CTRL_IRQ_EN  = 2;

   localparam int STAT_OVF_BIT    = 16;
   localparam int STAT_IRQ_EN_BIT = 17;
   localparam int DATA_VALID_BIT  = 31;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      RD_IDLE  = 1'b0,
      RD_FETCH = 1'b1
   } rd_state_t;

endpackage

// File: rtl/kbd_sync_fifo.sv
// Synchronous FIFO with flush; a pop on a full FIFO frees the slot for a
// same-cycle push.
module kbd_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [2**AW];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(2**AW));
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/kbd_scancode_regs.sv
// ASHI register handler buffering PS/2 scancodes behind STATUS/DATA/CONTROL/ID.
// Optional KBD_TIMESTAMP_EN tags each buffered byte with a 16-bit tick count.
//
//  state    | meaning
//  ---------+-----------------------------------------------
//  RD_IDLE  | waiting for ASHI_READ, RIDLE high
//  RD_FETCH | index latched; response and DATA pop at exit
module kbd_scancode_regs
   import kbd_regs_pkg::*;
#(
   parameter int          FIFO_AW     = 4,
   parameter logic [31:0] ID_VALUE    = 32'h4B42_0001,
   parameter int          TS_PRESCALE = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  kbd_data,
   input  logic        kbd_valid,
   input  logic [31:0] ASHI_WINDX,
   input  logic [31:0] ASHI_WDATA,
   input  logic        ASHI_WRITE,
   output logic        ASHI_WIDLE,
   output logic [1:0]  ASHI_WRESP,
   input  logic [31:0] ASHI_RINDX,
   input  logic        ASHI_READ,
   output logic        ASHI_RIDLE,
   output logic [31:0] ASHI_RDATA,
   output logic [1:0]  ASHI_RRESP,
   output logic        irq
);

`ifdef KBD_TIMESTAMP_EN
   localparam int FW = 24;
`else
   localparam int FW = 8;
`endif

   rd_state_t      rd_state;
   logic [1:0]     rd_idx_q;
   logic           rd_mapped_q;
   logic           overflow;
   logic           irq_en;
   logic [FW-1:0]  fifo_wdata;
   logic [FW-1:0]  fifo_rdata;
   logic           fifo_full;
   logic           fifo_empty;
   logic [FIFO_AW:0] fifo_count;
   logic           wr_mapped;
   logic           ctrl_wr;
   logic           flush;
   logic           clr_ovf;
   logic           pop;
   logic           ovf_set;
   logic [31:0]    rd_value;
   logic           wdata_unused;

   assign ASHI_WIDLE   = 1'b1;
   assign wdata_unused = ^ASHI_WDATA[31:3];

   assign wr_mapped = (ASHI_WINDX[31:2] == 30'd0);
   assign ctrl_wr   = ASHI_WRITE & wr_mapped & (ASHI_WINDX[1:0] == REG_CONTROL);
   assign flush     = ctrl_wr & ASHI_WDATA[CTRL_FLUSH];
   assign clr_ovf   = ctrl_wr & ASHI_WDATA[CTRL_CLR_OVF];

   assign pop     = (rd_state == RD_FETCH) & rd_mapped_q & (rd_idx_q == REG_DATA);
   // A full FIFO with a same-cycle pop still has room, so only a pop-less push drops.
   assign ovf_set = kbd_valid & fifo_full & ~pop;

`ifdef KBD_TIMESTAMP_EN
   localparam int PSW = (TS_PRESCALE > 1) ? $clog2(TS_PRESCALE) : 1;
   logic [PSW-1:0] ps_cnt;
   logic [15:0]    ts_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         ps_cnt <= PSW'(TS_PRESCALE - 1);
         ts_cnt <= '0;
      end else if (ps_cnt == '0) begin
         ps_cnt <= PSW'(TS_PRESCALE - 1);
         ts_cnt <= ts_cnt + 16'd1;
      end else begin
         ps_cnt <= ps_cnt - PSW'(1);
      end
   end

   assign fifo_wdata = {ts_cnt, kbd_data};
`else
   localparam int ts_prescale_unused = TS_PRESCALE;
   assign fifo_wdata = kbd_data;
`endif

   kbd_sync_fifo #(
      .WIDTH (FW),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (kbd_valid),
      .pop   (pop),
      .flush (flush),
      .wdata (fifo_wdata),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      rd_value = '0;
      if (rd_mapped_q) begin
         case (rd_idx_q)
            REG_STATUS: begin
               rd_value[FIFO_AW:0]       = fifo_count;
               rd_value[STAT_OVF_BIT]    = overflow;
               rd_value[STAT_IRQ_EN_BIT] = irq_en;
            end
            REG_DATA: begin
               if (!fifo_empty) begin
                  rd_value[DATA_VALID_BIT] = 1'b1;
                  rd_value[FW-1:0]         = fifo_rdata;
               end
            end
            REG_CONTROL: rd_value[CTRL_IRQ_EN] = irq_en;
            default:     rd_value = ID_VALUE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_state    <= RD_IDLE;
         rd_idx_q    <= '0;
         rd_mapped_q <= 1'b0;
         ASHI_RIDLE  <= 1'b1;
         ASHI_RDATA  <= '0;
         ASHI_RRESP  <= RESP_OKAY;
         ASHI_WRESP  <= RESP_OKAY;
         overflow    <= 1'b0;
         irq_en      <= 1'b0;
         irq         <= 1'b0;
      end else begin
         case (rd_state)
            RD_IDLE: begin
               if (ASHI_READ) begin
                  rd_idx_q    <= ASHI_RINDX[1:0];
                  rd_mapped_q <= (ASHI_RINDX[31:2] == 30'd0);
                  rd_state    <= RD_FETCH;
                  ASHI_RIDLE  <= 1'b0;
               end
            end
            default: begin
               ASHI_RDATA <= rd_value;
               ASHI_RRESP <= rd_mapped_q ? RESP_OKAY : RESP_SLVERR;
               rd_state   <= RD_IDLE;
               ASHI_RIDLE <= 1'b1;
            end
         endcase

         if (ASHI_WRITE) begin
            ASHI_WRESP <= ctrl_wr ? RESP_OKAY : RESP_SLVERR;
            if (ctrl_wr) irq_en <= ASHI_WDATA[CTRL_IRQ_EN];
         end

         if (ovf_set)      overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;

         irq <= irq_en & ~fifo_empty;
      end
   end

endmodule

// File: tb/tb_kbd_scancode_regs.sv
// Directed self-checking bench for kbd_scancode_regs (default and
// KBD_TIMESTAMP_EN builds).
module tb_kbd_scancode_regs;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  kbd_data;
   logic        kbd_valid;
   logic [31:0] ASHI_WINDX;
   logic [31:0] ASHI_WDATA;
   logic        ASHI_WRITE;
   logic        ASHI_WIDLE;
   logic [1:0]  ASHI_WRESP;
   logic [31:0] ASHI_RINDX;
   logic        ASHI_READ;
   logic        ASHI_RIDLE;
   logic [31:0] ASHI_RDATA;
   logic [1:0]  ASHI_RRESP;
   logic        irq;

   int errors = 0;
   int checks = 0;

`ifdef KBD_TIMESTAMP_EN
   localparam logic [31:0] DMASK = 32'hFF00_00FF;
`else
   localparam logic [31:0] DMASK = 32'hFFFF_FFFF;
`endif

   kbd_scancode_regs #(
      .FIFO_AW     (4),
      .ID_VALUE    (32'h4B42_0001),
      .TS_PRESCALE (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .kbd_data   (kbd_data),
      .kbd_valid  (kbd_valid),
      .ASHI_WINDX (ASHI_WINDX),
      .ASHI_WDATA (ASHI_WDATA),
      .ASHI_WRITE (ASHI_WRITE),
      .ASHI_WIDLE (ASHI_WIDLE),
      .ASHI_WRESP (ASHI_WRESP),
      .ASHI_RINDX (ASHI_RINDX),
      .ASHI_READ  (ASHI_READ),
      .ASHI_RIDLE (ASHI_RIDLE),
      .ASHI_RDATA (ASHI_RDATA),
      .ASHI_RRESP (ASHI_RRESP),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      kbd_data  = b;
      kbd_valid = 1'b1;
      tick();
      kbd_valid = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] idx, input logic [31:0] data);
      ASHI_WINDX = idx;
      ASHI_WDATA = data;
      ASHI_WRITE = 1'b1;
      tick();
      ASHI_WRITE = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] idx, output logic [31:0] data,
                          output logic [1:0] resp, output int low);
      int n;
      ASHI_RINDX = idx;
      ASHI_READ  = 1'b1;
      tick();
      ASHI_READ = 1'b0;
      low = 0;
      n   = 0;
      while (ASHI_RIDLE !== 1'b1 && n < 8) begin
         low++;
         tick();
         n++;
      end
      chk("read_done", {31'd0, ASHI_RIDLE}, 32'd1);
      data = ASHI_RDATA;
      resp = ASHI_RRESP;
   endtask

   initial begin
      logic [31:0] d, d2;
      logic [1:0]  r;
      int          low;

      reset = 1'b1;
      kbd_data = '0; kbd_valid = 1'b0;
      ASHI_WINDX = '0; ASHI_WDATA = '0; ASHI_WRITE = 1'b0;
      ASHI_RINDX = '0; ASHI_READ = 1'b0;
      repeat (3) tick();
      reset = 1'b0;

      // reset state
      chk("rst_ridle", {31'd0, ASHI_RIDLE}, 32'd1);
      chk("rst_widle", {31'd0, ASHI_WIDLE}, 32'd1);
      chk("rst_rdata", ASHI_RDATA, 32'd0);
      chk("rst_rresp", {30'd0, ASHI_RRESP}, 32'd0);
      chk("rst_wresp", {30'd0, ASHI_WRESP}, 32'd0);
      chk("rst_irq",   {31'd0, irq}, 32'd0);
      do_read(32'd0, d, r, low);
      chk("rst_status", d, 32'd0);

      // 1: three scancodes out in order
      push(8'h1C); push(8'hF0); push(8'h1C);
      do_read(32'd1, d, r, low); chk("t1_data0", d & DMASK, 32'h8000_001C);
      chk("t1_resp", {30'd0, r}, 32'd0);
      do_read(32'd1, d, r, low); chk("t1_data1", d & DMASK, 32'h8000_00F0);
      do_read(32'd1, d, r, low); chk("t1_data2", d & DMASK, 32'h8000_001C);
      do_read(32'd0, d, r, low); chk("t1_status", d, 32'd0);
      do_read(32'd1, d, r, low); chk("t1_empty_data", d, 32'd0);

      // 2: overflow on the 17th byte, then clear
      for (int i = 0; i < 17; i++) push(8'h40 + 8'(i));
      do_read(32'd0, d, r, low); chk("t2_status_ovf", d, 32'h0001_0010);
      do_write(32'd2, 32'd2);
      chk("t2_wresp", {30'd0, ASHI_WRESP}, 32'd0);
      do_read(32'd0, d, r, low); chk("t2_status_clr", d, 32'h0000_0010);

      // 3: push coincident with the DATA pop on a full FIFO
      ASHI_RINDX = 32'd1;
      ASHI_READ  = 1'b1;
      tick();
      ASHI_READ = 1'b0;
      chk("t3_fetch_ridle", {31'd0, ASHI_RIDLE}, 32'd0);
      kbd_data  = 8'h55;
      kbd_valid = 1'b1;
      tick();
      kbd_valid = 1'b0;
      chk("t3_data", ASHI_RDATA & DMASK, 32'h8000_0040);
      do_read(32'd0, d, r, low); chk("t3_status", d, 32'h0000_0010);
      // overflow set and clear in the same cycle: set wins
      kbd_data   = 8'h66;
      kbd_valid  = 1'b1;
      ASHI_WINDX = 32'd2;
      ASHI_WDATA = 32'd2;
      ASHI_WRITE = 1'b1;
      tick();
      kbd_valid  = 1'b0;
      ASHI_WRITE = 1'b0;
      do_read(32'd0, d, r, low); chk("t3_set_wins", d, 32'h0001_0010);
      do_write(32'd2, 32'd3);
      do_read(32'd0, d, r, low); chk("t3_flush_clr", d, 32'd0);

      // 4: interrupt
      do_write(32'd2, 32'd4);
      do_read(32'd2, d, r, low); chk("t4_ctrl_rd", d, 32'h0000_0004);
      chk("t4_irq_idle", {31'd0, irq}, 32'd0);
      push(8'h29);
      chk("t4_irq_lag", {31'd0, irq}, 32'd0);
      tick();
      chk("t4_irq_on", {31'd0, irq}, 32'd1);
      do_read(32'd1, d, r, low); chk("t4_data", d & DMASK, 32'h8000_0029);
      tick();
      chk("t4_irq_off", {31'd0, irq}, 32'd0);
      push(8'h11);
      tick();
      chk("t4_irq_on2", {31'd0, irq}, 32'd1);
      do_write(32'd2, 32'd1);
      tick();
      chk("t4_irq_flush", {31'd0, irq}, 32'd0);
      do_read(32'd0, d, r, low); chk("t4_status", d, 32'd0);

      // 5: unmapped and illegal accesses
      do_read(32'd7, d, r, low);
      chk("t5_rd7_data", d, 32'd0);
      chk("t5_rd7_resp", {30'd0, r}, 32'd2);
      chk("t5_ridle_low", low, 32'd1);
      do_read(32'h8000_0001, d, r, low);
      chk("t5_rdhi_resp", {30'd0, r}, 32'd2);
      do_write(32'd3, 32'hFFFF_FFFF);
      chk("t5_wr_id_resp", {30'd0, ASHI_WRESP}, 32'd2);
      do_read(32'd3, d, r, low);
      chk("t5_id", d, 32'h4B42_0001);
      chk("t5_id_resp", {30'd0, r}, 32'd0);
      do_write(32'd2, 32'd0);
      chk("t5_wr_ctrl_resp", {30'd0, ASHI_WRESP}, 32'd0);
      do_write(32'd6, 32'd4);
      chk("t5_wr6_resp", {30'd0, ASHI_WRESP}, 32'd2);
      do_write(32'd0, 32'd4);
      chk("t5_wr0_resp", {30'd0, ASHI_WRESP}, 32'd2);
      do_read(32'd2, d, r, low); chk("t5_ctrl_unchanged", d, 32'd0);

      // 6: reset during FETCH
      push(8'h33);
      ASHI_RINDX = 32'd1;
      ASHI_READ  = 1'b1;
      tick();
      ASHI_READ = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_ridle", {31'd0, ASHI_RIDLE}, 32'd1);
      chk("t6_rdata", ASHI_RDATA, 32'd0);
      do_read(32'd0, d, r, low); chk("t6_status", d, 32'd0);

`ifdef KBD_TIMESTAMP_EN
      push(8'h01);
      repeat (20) tick();
      push(8'h02);
      do_read(32'd1, d, r, low);
      do_read(32'd1, d2, r, low);
      chk("t6_ts_ascend", {31'd0, (d2[23:8] > d[23:8])}, 32'd1);
      chk("t6_ts_byte", d2 & DMASK, 32'h8000_0002);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
